// File: rtl/ltile_fle_cfgchain_pkg.sv
// Shared definitions for the configurable fracturable logic element:
// configuration word field offsets and the flop D-source encoding.
package fle_cfg_pkg;

   typedef enum logic {
      D_LUT   = 1'b0,
      D_CHAIN = 1'b1
   } dsrc_e;

   // Word layout, LSB first: truth table, osel[1:0], dsel[1:0], frac_mode.
   function automatic int CFG_LEN_OF(input int k);
      return (1 << k) + 5;
   endfunction

   function automatic int TT_LSB(input int k);
      return 0 * k;
   endfunction

   function automatic int OSEL_LSB(input int k);
      return 1 << k;
   endfunction

   function automatic int DSEL_LSB(input int k);
      return (1 << k) + 2;
   endfunction

   function automatic int FRAC_BIT(input int k);
      return (1 << k) + 4;
   endfunction

endpackage

// File: rtl/ltile_fle_cfgchain_shreg.sv
// Configuration shift register with a saturating bit counter; cfg_valid is
// raised only when prog_en drops after at least CFG_LEN shifts.
module fle_cfg_shreg #(
   parameter int CFG_LEN = 21
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               prog_en,
   input  logic               ccff_head,
   output logic [CFG_LEN-1:0] cfg,
   output logic               ccff_tail,
   output logic               cfg_valid
);

   localparam int CNT_W = $clog2(CFG_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

   logic [CNT_W-1:0] count;
   logic             prog_en_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cfg       <= '0;
         count     <= '0;
         cfg_valid <= 1'b0;
         prog_en_q <= 1'b0;
      end else begin
         prog_en_q <= prog_en;
         if (prog_en) begin
            cfg <= {cfg[CFG_LEN-2:0], ccff_head};
            // A fresh prog_en burst restarts the count; this shift is bit 1.
            if (!prog_en_q) begin
               count     <= CNT_W'(1);
               cfg_valid <= 1'b0;
            end else if (count != CNT_FULL) begin
               count <= count + 1'b1;
            end
         end else if (prog_en_q) begin
            cfg_valid <= (count == CNT_FULL);
         end
      end
   end

   assign ccff_tail = cfg[CFG_LEN-1];

endmodule

// File: rtl/ltile_fle_cfgchain.sv
// Fracturable K-input LUT with two user flops, scan path and output muxes,
// configured through a native shift chain whose outputs are gated until loaded.
module ltile_fle_cfgchain
   import fle_cfg_pkg::*;
#(
   parameter int LUT_K = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             prog_en,
   input  logic             ccff_head,
   output logic             ccff_tail,
   input  logic             Test_en,
   input  logic [LUT_K-1:0] fabric_in,
   input  logic             fabric_regin,
   input  logic             fabric_sc_in,
   output logic [1:0]       fabric_out,
   output logic             fabric_regout,
   output logic             fabric_sc_out,
   output logic             cfg_valid
);

   localparam int CFG_LEN = CFG_LEN_OF(LUT_K);
   localparam int TT_W    = 1 << LUT_K;
   localparam int TT_L    = TT_LSB(LUT_K);
   localparam int OSEL_L  = OSEL_LSB(LUT_K);
   localparam int DSEL_L  = DSEL_LSB(LUT_K);
   localparam int FRAC_B  = FRAC_BIT(LUT_K);

   logic [CFG_LEN-1:0] cfg;
   logic [TT_W-1:0]    tt;
   logic [1:0]         osel;
   logic [1:0]         dsel;
   logic               frac_mode;
   logic [LUT_K-1:0]   addr0;
   logic [LUT_K-1:0]   addr1;
   logic               lut0;
   logic               lut1;
   logic               ff0;
   logic               ff1;
   logic               out_en;
   dsrc_e              d0_src;
   dsrc_e              d1_src;

   fle_cfg_shreg #(
      .CFG_LEN (CFG_LEN)
   ) u_shreg (
      .clk       (clk),
      .reset_n   (reset_n),
      .prog_en   (prog_en),
      .ccff_head (ccff_head),
      .cfg       (cfg),
      .ccff_tail (ccff_tail),
      .cfg_valid (cfg_valid)
   );

   assign tt        = cfg[TT_L +: TT_W];
   assign osel      = cfg[OSEL_L +: 2];
   assign dsel      = cfg[DSEL_L +: 2];
   assign frac_mode = cfg[FRAC_B];
   assign d0_src    = dsrc_e'(dsel[0]);
   assign d1_src    = dsrc_e'(dsel[1]);

   // Fractured: the top address bit selects the half of the table instead of fabric_in.
   always_comb begin
      addr0 = fabric_in;
      addr1 = fabric_in;
      if (frac_mode) begin
         addr0 = {1'b0, fabric_in[LUT_K-2:0]};
         addr1 = {1'b1, fabric_in[LUT_K-2:0]};
      end
   end

   assign lut0 = tt[addr0];
   assign lut1 = tt[addr1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ff0 <= 1'b0;
         ff1 <= 1'b0;
      end else if (!prog_en) begin
         if (Test_en) begin
            ff0 <= fabric_sc_in;
            ff1 <= ff0;
         end else begin
            ff0 <= (d0_src == D_CHAIN) ? fabric_regin : lut0;
            ff1 <= (d1_src == D_CHAIN) ? ff0 : lut1;
         end
      end
   end

   assign out_en        = cfg_valid & ~prog_en;
   assign fabric_out[0] = out_en & (osel[0] ? ff0 : lut0);
   assign fabric_out[1] = out_en & (osel[1] ? ff1 : lut1);
   assign fabric_regout = ff1;
   assign fabric_sc_out = ff1;

endmodule

// File: tb/tb_ltile_fle_cfgchain.sv
// Directed bench for ltile_fle_cfgchain with LUT_K=4 (21-bit configuration word).
module tb_ltile_fle_cfgchain;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       prog_en = 1'b0;
   logic       ccff_head = 1'b0;
   logic       ccff_tail;
   logic       Test_en = 1'b0;
   logic [3:0] fabric_in = 4'h0;
   logic       fabric_regin = 1'b0;
   logic       fabric_sc_in = 1'b0;
   logic [1:0] fabric_out;
   logic       fabric_regout;
   logic       fabric_sc_out;
   logic       cfg_valid;

   int n_assert = 0;
   int n_fail   = 0;

   ltile_fle_cfgchain #(.LUT_K(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .prog_en       (prog_en),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .Test_en       (Test_en),
      .fabric_in     (fabric_in),
      .fabric_regin  (fabric_regin),
      .fabric_sc_in  (fabric_sc_in),
      .fabric_out    (fabric_out),
      .fabric_regout (fabric_regout),
      .fabric_sc_out (fabric_sc_out),
      .cfg_valid     (cfg_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Word is {frac, dsel[1:0], osel[1:0], tt[15:0]}; MSB goes in first.
   task automatic shift_word(input logic [20:0] w);
      for (int i = 20; i >= 0; i--) begin
         prog_en   = 1'b1;
         ccff_head = w[i];
         tick();
      end
      prog_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   logic [20:0] w_and4, w_frac, w_chain, w_ones;
   logic [41:0] pat;

   initial begin
      w_and4  = {1'b0, 2'b00, 2'b00, 16'h8000};
      w_frac  = {1'b1, 2'b00, 2'b00, 16'h0100};
      w_chain = {1'b0, 2'b11, 2'b11, 16'h0000};
      w_ones  = {1'b1, 2'b11, 2'b11, 16'hFFFF};
      pat     = 42'h2A5_C3F0_96E1;

      // Reset state
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      chk("rst_valid", cfg_valid, 0);
      chk("rst_out", fabric_out, 0);
      chk("rst_tail", ccff_tail, 0);
      chk("rst_regout", fabric_regout, 0);
      chk("rst_scout", fabric_sc_out, 0);

      // 4-input AND load
      shift_word(w_and4);
      fabric_in = 4'hF;
      chk("load_valid_pending", cfg_valid, 0);
      tick();
      chk("load_valid", cfg_valid, 1);
      chk("and_F", fabric_out, 2'b11);
      fabric_in = 4'hE;
      #1;
      chk("and_E", fabric_out, 2'b00);

      // Aborted load after 10 shifts
      for (int i = 0; i < 10; i++) begin
         prog_en   = 1'b1;
         ccff_head = 1'b1;
         tick();
      end
      prog_en = 1'b0;
      tick();
      chk("abort_valid", cfg_valid, 0);
      fabric_in = 4'hF;
      #1;
      chk("abort_out_F", fabric_out, 0);
      fabric_in = 4'h0;
      #1;
      chk("abort_out_0", fabric_out, 0);
      shift_word(w_and4);
      tick();
      chk("reload_valid", cfg_valid, 1);
      fabric_in = 4'hF;
      #1;
      chk("reload_and_F", fabric_out, 2'b11);

      // Fractured mode
      shift_word(w_frac);
      tick();
      chk("frac_valid", cfg_valid, 1);
      fabric_in = 4'h0;
      #1;
      chk("frac_in0", fabric_out, 2'b10);
      fabric_in = 4'h8;
      #1;
      chk("frac_in8", fabric_out, 2'b10);
      fabric_in = 4'h1;
      #1;
      chk("frac_in1", fabric_out, 2'b00);

      // Register chain: ff0 from regin, ff1 from ff0, both routed out
      fabric_regin = 1'b0;
      shift_word(w_chain);
      tick();
      tick();
      tick();
      chk("chain_flush_out", fabric_out, 2'b00);
      chk("chain_flush_regout", fabric_regout, 0);
      fabric_regin = 1'b1;
      tick();
      fabric_regin = 1'b0;
      chk("chain_out_1", fabric_out, 2'b01);
      chk("chain_regout_1", fabric_regout, 0);
      tick();
      chk("chain_out_2", fabric_out, 2'b10);
      chk("chain_regout_2", fabric_regout, 1);

      // Scan path
      Test_en      = 1'b1;
      fabric_sc_in = 1'b0;
      tick();
      tick();
      chk("scan_flush", fabric_sc_out, 0);
      fabric_sc_in = 1'b1;
      tick();
      fabric_sc_in = 1'b0;
      tick();
      chk("scan_b0", fabric_sc_out, 1);
      fabric_sc_in = 1'b1;
      tick();
      chk("scan_b1", fabric_sc_out, 0);
      fabric_sc_in = 1'b0;
      tick();
      chk("scan_b2", fabric_sc_out, 1);
      // ff0=0, ff1=1 now; prog_en must freeze both against Test_en
      fabric_sc_in = 1'b1;
      prog_en      = 1'b1;
      tick();
      prog_en = 1'b0;
      chk("freeze_ff1", fabric_sc_out, 1);
      tick();
      chk("freeze_ff0", fabric_sc_out, 0);
      Test_en      = 1'b0;
      fabric_sc_in = 1'b0;

      // Chain passthrough, head to tail latency of 21 shifts
      for (int k = 1; k <= 42; k++) begin
         prog_en   = 1'b1;
         ccff_head = pat[k-1];
         tick();
         if (k >= 21) chk($sformatf("tail_%0d", k), ccff_tail, pat[k-21]);
      end
      prog_en   = 1'b0;
      ccff_head = 1'b0;
      tick();

      // Reset in the middle of a load
      shift_word(w_ones);
      tick();
      chk("pre_rst_valid", cfg_valid, 1);
      for (int i = 0; i < 4; i++) begin
         prog_en   = 1'b1;
         ccff_head = 1'b0;
         tick();
      end
      chk("pre_rst_tail", ccff_tail, 1);
      reset_n = 1'b0;
      tick();
      chk("midrst_valid", cfg_valid, 0);
      chk("midrst_tail", ccff_tail, 0);
      chk("midrst_out", fabric_out, 0);
      reset_n = 1'b1;
      prog_en = 1'b0;
      tick();
      chk("post_rst_valid", cfg_valid, 0);
      chk("post_rst_out", fabric_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
